// File: rtl/inst_queue_pkg.sv
// inst_queue_pkg: front-end types and instruction queue constants.
package inst_queue_pkg;

    typedef logic [31:0] virt_t;
    typedef logic [31:0] uint32_t;

    typedef struct packed {
        logic       ex;
        logic [4:0] exccode;
    } exception_t;

    typedef struct packed {
        virt_t      pc;
        uint32_t    inst;
        exception_t exc;
    } fetch_entry_t;

    localparam int INST_QUEUE_DEPTH = 16;
    localparam logic [4:0] EXC_ADEL = 5'h04;

endpackage

// File: rtl/inst_queue.sv
// inst_queue: dual-issue fetch-to-decode FIFO, two pushes and two lanes per cycle.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = INST_QUEUE_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 flush,
    input  logic [1:0]           enq_valid,
    input  virt_t [1:0]          enq_pc,
    input  uint32_t [1:0]        enq_inst,
    input  exception_t [1:0]     enq_exc,
    output logic                 enq_ready,
    input  logic                 deq_ready,
    output logic [1:0]           deq_valid,
    output virt_t [1:0]          deq_pc,
    output uint32_t [1:0]        deq_inst,
    output exception_t [1:0]     deq_exc,
    output logic [PTR_W:0]       count
);

    localparam int CW = PTR_W + 1;

    logic [PTR_W:0]   head, tail, cnt;
    logic [PTR_W-1:0] wr0, wr1, rd0, rd1;
    logic             do_push, do_pop;
    logic [1:0]       n_push, n_pop;
    fetch_entry_t     mem [DEPTH];
    fetch_entry_t     e0, e1;

    assign wr0 = tail[PTR_W-1:0];
    assign wr1 = wr0 + 1'b1;
    assign rd0 = head[PTR_W-1:0];
    assign rd1 = rd0 + 1'b1;

    // Ready depends only on registered occupancy so fetch never sees a path from decode.
    assign enq_ready = cnt <= CW'(DEPTH - 2);
    assign deq_valid = {cnt >= CW'(2), cnt != '0};
    assign count     = cnt;

    assign do_push = enq_ready && !flush;
    assign do_pop  = deq_ready && !flush;
    assign n_push  = do_push ? {1'b0, enq_valid[1]} + {1'b0, enq_valid[0]} : 2'd0;
    assign n_pop   = do_pop  ? {1'b0, deq_valid[1]} + {1'b0, deq_valid[0]} : 2'd0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            head <= flush ? '0 : head + CW'(n_pop);
            tail <= flush ? '0 : tail + CW'(n_push);
            cnt  <= flush ? '0 : cnt + CW'(n_push) - CW'(n_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && enq_valid[0])
            mem[wr0] <= '{pc: enq_pc[0], inst: enq_inst[0], exc: enq_exc[0]};
        if (do_push && enq_valid[1])
            mem[wr1] <= '{pc: enq_pc[1], inst: enq_inst[1], exc: enq_exc[1]};
    end

    assign e0       = mem[rd0];
    assign e1       = mem[rd1];
    assign deq_pc   = {e1.pc, e0.pc};
    assign deq_inst = {e1.inst, e0.inst};
    assign deq_exc  = {e1.exc, e0.exc};

    a_enq_order: assert property (@(posedge clk) disable iff (!resetn) enq_valid != 2'b10);
    a_cnt_max:   assert property (@(posedge clk) disable iff (!resetn) cnt <= CW'(DEPTH));
    a_cnt_ptr:   assert property (@(posedge clk) disable iff (!resetn) cnt == CW'(tail - head));

endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: directed self-checking bench for inst_queue.
module tb_inst_queue;
    import inst_queue_pkg::*;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             flush = 1'b0;
    logic [1:0]       enq_valid = '0;
    virt_t [1:0]      enq_pc = '0;
    uint32_t [1:0]    enq_inst = '0;
    exception_t [1:0] enq_exc = '0;
    logic             enq_ready;
    logic             deq_ready = 1'b0;
    logic [1:0]       deq_valid;
    virt_t [1:0]      deq_pc;
    uint32_t [1:0]    deq_inst;
    exception_t [1:0] deq_exc;
    logic [4:0]       count;

    int vectors = 0;
    int miscompares = 0;

    inst_queue dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .enq_valid(enq_valid), .enq_pc(enq_pc), .enq_inst(enq_inst), .enq_exc(enq_exc),
        .enq_ready(enq_ready), .deq_ready(deq_ready), .deq_valid(deq_valid),
        .deq_pc(deq_pc), .deq_inst(deq_inst), .deq_exc(deq_exc), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push2(input virt_t p0, input virt_t p1);
        enq_valid = 2'b11;
        enq_pc    = {p1, p0};
        enq_inst  = {p1 ^ 32'h5a5a0000, p0 ^ 32'h5a5a0000};
        enq_exc   = '0;
    endtask

    task automatic idle();
        enq_valid = 2'b00;
        deq_ready = 1'b0;
        flush     = 1'b0;
    endtask

    initial begin
        #12;
        check("reset_deq_valid", 64'(deq_valid), 64'd0);
        check("reset_enq_ready", 64'(enq_ready), 64'd1);
        check("reset_count", 64'(count), 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;

        // 1: two-wide push, visible next cycle
        enq_valid = 2'b11;
        enq_pc    = {32'hBFC00004, 32'hBFC00000};
        enq_inst  = {32'h24090002, 32'h24080001};
        enq_exc   = '0;
        tick();
        idle();
        check("t1_deq_valid", 64'(deq_valid), 64'd3);
        check("t1_pc0", 64'(deq_pc[0]), 64'hBFC00000);
        check("t1_pc1", 64'(deq_pc[1]), 64'hBFC00004);
        check("t1_inst0", 64'(deq_inst[0]), 64'h24080001);
        check("t1_inst1", 64'(deq_inst[1]), 64'h24090002);
        check("t1_count", 64'(count), 64'd2);

        // 2: flush to empty, then fill with 8 two-wide pushes
        flush = 1'b1;
        tick();
        idle();
        check("t2_flush_count", 64'(count), 64'd0);
        for (int k = 0; k < 8; k++) begin
            push2(32'h100 + 32'(8 * k), 32'h104 + 32'(8 * k));
            tick();
        end
        idle();
        check("t2_full_count", 64'(count), 64'd16);
        check("t2_full_ready", 64'(enq_ready), 64'd0);
        push2(32'hDEAD0000, 32'hDEAD0004);
        tick();
        idle();
        check("t2_blocked_count", 64'(count), 64'd16);
        check("t2_blocked_pc0", 64'(deq_pc[0]), 64'h100);
        deq_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("t2_drain_pc0", 64'(deq_pc[0]), 64'(32'h100 + 32'(8 * k)));
            check("t2_drain_pc1", 64'(deq_pc[1]), 64'(32'h104 + 32'(8 * k)));
            tick();
        end
        idle();
        check("t2_drained_count", 64'(count), 64'd0);
        check("t2_drained_valid", 64'(deq_valid), 64'd0);

        // 3: count=1, pop one while pushing two
        enq_valid = 2'b01;
        enq_pc    = {32'h0, 32'h200};
        tick();
        idle();
        check("t3_count1", 64'(count), 64'd1);
        check("t3_valid1", 64'(deq_valid), 64'd1);
        push2(32'h204, 32'h208);
        deq_ready = 1'b1;
        tick();
        idle();
        check("t3_count", 64'(count), 64'd2);
        check("t3_pc0", 64'(deq_pc[0]), 64'h204);
        check("t3_pc1", 64'(deq_pc[1]), 64'h208);

        // 4: steady push/pop until tail index 15, then straddling push
        for (int k = 0; k < 6; k++) begin
            push2(32'h20C + 32'(8 * k), 32'h210 + 32'(8 * k));
            deq_ready = 1'b1;
            tick();
        end
        idle();
        check("t4_pre_count", 64'(count), 64'd2);
        check("t4_pre_pc0", 64'(deq_pc[0]), 64'h234);
        push2(32'h23C, 32'h240);
        tick();
        idle();
        check("t4_wrap_count", 64'(count), 64'd4);
        check("t4_wrap_pc1", 64'(deq_pc[1]), 64'h238);
        deq_ready = 1'b1;
        tick();
        check("t4_wrap_rd_pc0", 64'(deq_pc[0]), 64'h23C);
        check("t4_wrap_rd_pc1", 64'(deq_pc[1]), 64'h240);
        check("t4_wrap_rd_inst1", 64'(deq_inst[1]), 64'(32'h240 ^ 32'h5a5a0000));
        tick();
        idle();
        check("t4_empty", 64'(count), 64'd0);

        // 5: flush overrides same-cycle push and pop
        for (int k = 0; k < 3; k++) begin
            push2(32'h280 + 32'(8 * k), 32'h284 + 32'(8 * k));
            tick();
        end
        idle();
        check("t5_count6", 64'(count), 64'd6);
        push2(32'hBAD00000, 32'hBAD00004);
        deq_ready = 1'b1;
        flush     = 1'b1;
        tick();
        idle();
        check("t5_count", 64'(count), 64'd0);
        check("t5_valid", 64'(deq_valid), 64'd0);
        check("t5_ready", 64'(enq_ready), 64'd1);
        enq_valid = 2'b01;
        enq_pc    = {32'h0, 32'h300};
        tick();
        idle();
        check("t5_after_count", 64'(count), 64'd1);
        check("t5_after_pc0", 64'(deq_pc[0]), 64'h300);

        // 6: exception entry carried through, then async reset mid-traffic
        enq_valid = 2'b01;
        enq_pc    = {32'h0, 32'h00000003};
        enq_inst  = '0;
        enq_exc   = {6'h0, 1'b1, EXC_ADEL};
        deq_ready = 1'b1;
        tick();
        idle();
        check("t6_count", 64'(count), 64'd1);
        check("t6_pc0", 64'(deq_pc[0]), 64'h3);
        check("t6_exc0", 64'(deq_exc[0]), 64'({1'b1, EXC_ADEL}));
        deq_ready = 1'b1;
        tick();
        idle();
        check("t6_popped", 64'(count), 64'd0);
        push2(32'h400, 32'h404);
        tick();
        push2(32'h408, 32'h40C);
        deq_ready = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        check("t6_async_valid", 64'(deq_valid), 64'd0);
        check("t6_async_count", 64'(count), 64'd0);
        check("t6_async_ready", 64'(enq_ready), 64'd1);
        idle();
        tick();
        resetn = 1'b1;
        tick();
        check("t6_post_valid", 64'(deq_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
